shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Multicycle shift/rotate sequencer for the 16-bit datapath. It accepts one shift request, then drives a single 1-bit shift stage once per cycle until the requested count is reached. It raises a one-cycle completion pulse and holds the result. It sits beside the execute stage as a low-area alternative to a full barrel shifter; the pipeline stalls while the sequencer is busy.

Parameters:
WIDTH, 16, data width in bits.
CNT_W, 4, shift-count width; the maximum shift is 2**CNT_W-1 (15).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
Start  input  1  request strobe; sampled only when the block is accepting.
In  input  WIDTH  operand; captured on an accepted Start.
Cnt  input  CNT_W  shift amount; captured on an accepted Start.
Op  input  2  operation, captured on an accepted Start: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.
Busy  output  1  high while an operation is in progress; Start is ignored.
Done  output  1  one-cycle pulse when Out holds a new result.
Out  output  WIDTH  registered result; stable between Done pulses.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, Busy=0, Done=0, Out=0, and the internal data, count and op registers all 0.
- States: IDLE, SHIFT, DONE, with a 2-bit encoding and a defined default (go to IDLE).
- IDLE:
  - Busy=0, Done=0.
  - Start=1: load data<=In, remaining<=Cnt, op_r<=Op.
  - Next state is DONE if Cnt==0, else SHIFT.
- SHIFT:
  - Busy=1, Done=0.
  - Each cycle: data<=stage(data, op_r) with the stage shift-enable tied to 1, and remaining<=remaining-1.
  - When remaining==1 (the final shift this cycle), next state is DONE.
  - Start is ignored, and In/Cnt/Op changes have no effect.
- DONE:
  - Done=1 and Busy=0 for exactly this cycle.
  - Out is loaded with data on entry to DONE, so Out is valid in the same cycle Done is high.
  - Start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise the next state is IDLE.
- Latency: Start sampled at edge 0 -> SHIFT for Cnt cycles -> Done high in cycle Cnt+1. A Cnt of 0 completes in 1 cycle; a Cnt of 15 completes in 16.
- Shift semantics per step:
  - Rotate: the bit shifted out re-enters at the opposite end.
  - Logical shift: zero fill.
  - No arithmetic right shift is provided.
- Out holds its value through IDLE and SHIFT of the next operation. It changes only when DONE is entered.
- The counter never wraps: remaining is decremented only in SHIFT, where it is >=1.
- Simultaneous Start and rst: rst wins; the request is dropped.
- Reset mid-SHIFT: the next cycle is IDLE with all outputs at reset values. The partial result is discarded.
- Start held high continuously: a new operation is accepted every IDLE/DONE cycle, with no duplicate acceptance inside SHIFT.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
1. In=0x8001, Cnt=1, Op=00, Start pulse -> Busy high for 1 cycle; Done high 2 cycles after the Start edge with Out=0x0003.
2. In=0xF000, Cnt=15, Op=11 -> Busy high for 15 cycles; Done in cycle 16 with Out=0x0001. Repeat with Op=10 on In=0x0001, Cnt=4 -> Out=0x1000.
3. In=0x1234, Cnt=0, any Op -> Done the next cycle with Out=0x1234 and Busy never asserted. Then In=0x0001, Cnt=4, Op=01 -> Out=0x0010.
4. Start with In=0x00FF, Cnt=8, Op=01, then pulse Start with different In/Cnt mid-SHIFT -> pulse ignored, Out=0xFF00. A Start held high in the DONE cycle with In=0xFF00, Cnt=8, Op=11 is accepted -> next Done gives Out=0x00FF.
5. Assert rst in the 3rd SHIFT cycle of a Cnt=10 operation -> the following cycle shows Busy=0, Done=0, Out=0. A fresh op (0x0001, Cnt=2, Op=00) then yields 0x0004 with correct latency.
6. Assert Start and rst in the same cycle -> no operation starts; Busy=0 and Done=0 for the following 20 cycles.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multicycle shift/rotate sequencer for the 16-bit datapath.
// It accepts one request and then applies a single 1-bit shift stage once per
// cycle until the requested count is exhausted. After that it pulses Done for
// one cycle and holds the result on Out until the next completion.
//
// Op encoding: 00 rotate left, 01 shift left logical,
//              10 rotate right, 11 shift right logical.

// One-bit shift/rotate stage. It passes the data through unchanged when
// i_en is low.
module shift_seq_stage #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_op,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  // Single-position move; rotates recirculate the exiting bit, shifts zero-fill.
  always_comb begin
    // NOTE: every output of a combinational block is given a value first, so
    // no path through the case can leave it unassigned and infer a latch.
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        2'b00:   o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
        2'b01:   o_data = {i_data[WIDTH-2:0], 1'b0};
        2'b10:   o_data = {i_data[0], i_data[WIDTH-1:1]};
        default: o_data = {1'b0, i_data[WIDTH-1:1]};
      endcase
    end
  end

endmodule

module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_remaining;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_stage;
  logic             w_accept;
  logic             w_shifting;
  logic             w_load_out;
  logic [WIDTH-1:0] w_out_next;

  // The shift stage is always enabled; the sequencer only advances it in SHIFT.
  shift_seq_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .i_data (r_data),
    .i_op   (r_op),
    .i_en   (1'b1),
    .o_data (w_stage)
  );

  // State register; reset drops any in-flight request or partial result.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so that every register
    // samples the pre-edge values, regardless of statement order.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, plus the acceptance and result-capture strobes.
  always_comb begin
    w_next_state = ST_IDLE;
    w_accept     = 1'b0;
    w_shifting   = 1'b0;
    w_load_out   = 1'b0;
    w_out_next   = r_out;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request exactly like IDLE, so requests can run
        // back to back.
        if (Start) begin
          w_accept = 1'b1;
          if (Cnt == '0) begin
            // A zero count completes at once with the operand unchanged.
            w_next_state = ST_DONE;
            w_load_out   = 1'b1;
            w_out_next   = In;
          end else begin
            w_next_state = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        w_shifting = 1'b1;
        if (r_remaining == CNT_W'(1)) begin
          // This is the final step: Out takes the post-shift value so that it
          // is valid in the same cycle Done is high.
          w_next_state = ST_DONE;
          w_load_out   = 1'b1;
          w_out_next   = w_stage;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Working registers: load on acceptance, step once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_remaining <= '0;
      r_op        <= '0;
    end else if (w_accept) begin
      r_data      <= In;
      r_remaining <= Cnt;
      r_op        <= Op;
    end else if (w_shifting) begin
      // r_remaining is at least 1 here, so the decrement never wraps.
      r_data      <= w_stage;
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  // Result register: changes only on entry to DONE, and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_load_out) begin
      r_out <= w_out_next;
    end
  end

  assign Busy = (r_state == ST_SHIFT);
  assign Done = (r_state == ST_DONE);
  assign Out  = r_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: directed scenarios followed by randomized
// requests, checked cycle by cycle against a behavioural reference model.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic [1:0]  Op;
  logic        Busy;
  logic        Done;
  logic [15:0] Out;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_out = 16'h0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .In    (In),
    .Cnt   (Cnt),
    .Op    (Op),
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result: the whole n-bit move is computed in a single step using 32-bit arithmetic.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int n, input logic [1:0] op);
    logic [31:0] w;
    logic [31:0] xx;
    xx = {16'h0, x};
    case (op)
      2'b00:   w = (xx << n) | (xx >> (16 - n));
      2'b01:   w = xx << n;
      2'b10:   w = (xx >> n) | (xx << (16 - n));
      default: w = xx >> n;
    endcase
    return w[15:0];
  endfunction

  // The caller must be at a negedge. The task issues one request and then
  // checks each cycle up to and including the Done cycle. It returns at the
  // negedge of the Done cycle. When noise is set, random Start pulses with
  // random operands are driven during SHIFT; these must be ignored.
  task automatic do_op(input logic [15:0] din, input int n, input logic [1:0] op, input bit noise);
    logic [15:0] want;
    want  = ref_shift(din, n, op);
    Start = 1'b1;
    In    = din;
    Cnt   = 4'(n);
    Op    = op;
    @(posedge clk);
    #1;
    Start = 1'b0;
    In    = 16'($urandom);
    Cnt   = 4'($urandom);
    Op    = 2'($urandom);
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge clk);
      if (j <= n) begin
        check("busy_shift", 32'(Busy), 32'd1);
        check("done_shift", 32'(Done), 32'd0);
        check("out_hold",   32'(Out),  32'(exp_out));
        if (noise && ($urandom_range(0, 1) == 1)) begin
          Start = 1'b1;
          In    = 16'($urandom);
          Cnt   = 4'($urandom);
          Op    = 2'($urandom);
          @(posedge clk);
          #1;
          Start = 1'b0;
        end
      end else begin
        exp_out = want;
        check("busy_done", 32'(Busy), 32'd0);
        check("done_done", 32'(Done), 32'd1);
        check("out_done",  32'(Out),  32'(exp_out));
      end
    end
  endtask

  // Check idle cycles. The caller must be at a negedge; the task returns at a negedge.
  task automatic idle_cycles(input int k);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      check("busy_idle", 32'(Busy), 32'd0);
      check("done_idle", 32'(Done), 32'd0);
      check("out_idle",  32'(Out),  32'(exp_out));
    end
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    In    = 16'h0;
    Cnt   = 4'h0;
    Op    = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_out",  32'(Out),  32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Directed: single rotate, maximum-count shift, rotate right.
    do_op(16'h8001, 1, 2'b00, 1'b0);
    check("t1_val", 32'(Out), 32'h0003);
    idle_cycles(1);
    do_op(16'hF000, 15, 2'b11, 1'b0);
    check("t2a_val", 32'(Out), 32'h0001);
    idle_cycles(1);
    do_op(16'h0001, 4, 2'b10, 1'b0);
    check("t2b_val", 32'(Out), 32'h1000);
    idle_cycles(1);

    // Directed: a zero count completes next cycle with Busy never set, then a shift left.
    do_op(16'h1234, 0, 2'b10, 1'b0);
    check("t3a_val", 32'(Out), 32'h1234);
    idle_cycles(1);
    do_op(16'h0001, 4, 2'b01, 1'b0);
    check("t3b_val", 32'(Out), 32'h0010);
    idle_cycles(1);

    // Directed: Start mid-SHIFT is ignored; a Start during DONE is accepted back to back.
    do_op(16'h00FF, 8, 2'b01, 1'b1);
    check("t4a_val", 32'(Out), 32'hFF00);
    do_op(16'hFF00, 8, 2'b11, 1'b0);
    check("t4b_val", 32'(Out), 32'h00FF);
    idle_cycles(1);

    // Directed: reset during the third SHIFT cycle of a Cnt=10 request.
    Start = 1'b1;
    In    = 16'hABCD;
    Cnt   = 4'd10;
    Op    = 2'b00;
    @(posedge clk);
    #1;
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_pre", 32'(Busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_out = 16'h0;
    @(negedge clk);
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_done", 32'(Done), 32'd0);
    check("t5_out",  32'(Out),  32'd0);
    do_op(16'h0001, 2, 2'b00, 1'b0);
    check("t5_val", 32'(Out), 32'h0004);
    idle_cycles(1);

    // Directed: Start together with rst is dropped.
    rst   = 1'b1;
    Start = 1'b1;
    In    = 16'h5A5A;
    Cnt   = 4'd3;
    Op    = 2'b01;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    Start = 1'b0;
    exp_out = 16'h0;
    idle_cycles(20);

    // Randomized requests, with random idle gaps (including none, for back-to-back) and ignored pulses.
    for (int k = 0; k < 150; k++) begin
      do_op(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
